// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage and IF/ID pipeline register for the RV32IM pipeline.
// Owns the PC and drives the instruction-memory read handshake. It also applies
// hazard stalls and branch/jump redirects, and uses a one-entry skid register to
// keep a word that returns while decode is stalled.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_read,
    output logic [31:0] imem_addr,
    input  logic        imem_busy,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic [31:0] instr_out,
    output logic        valid_out
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Redirect targets are always forced to a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] pending_r;
    logic [31:0] skid_r;
    logic [31:0] pc_out_r;
    logic [31:0] pc_plus4_r;
    logic [31:0] instr_r;
    logic        valid_r;
    logic        read_r;

    logic [31:0] target_s;
    logic [31:0] pc_inc_s;

    assign target_s = word_align(branch_target);
    assign pc_inc_s = pc_r + 32'd4;

    // The PC only changes when an access has completed or the stage is redirected.
    // So the PC is also the address held stable during an outstanding or flushed access.
    assign imem_addr    = pc_r;
    // Reset masks the request combinationally so nothing is requested while reset is held.
    assign imem_read    = reset & read_r;
    assign pc_out       = pc_out_r;
    assign pc_plus4_out = pc_plus4_r;
    assign instr_out    = instr_r;
    assign valid_out    = valid_r;

    // Fetch control FSM with the PC, skid entry, pending target and IF/ID register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= FETCH;
            pc_r       <= RESET_PC;
            pending_r  <= 32'h0000_0000;
            skid_r     <= NOP_INSTR;
            pc_out_r   <= 32'h0000_0000;
            pc_plus4_r <= 32'h0000_0004;
            instr_r    <= NOP_INSTR;
            valid_r    <= 1'b0;
            read_r     <= 1'b1;
        end else begin
            case (state_r)
                FETCH: begin
                    if (branch_taken) begin
                        // Redirect beats stall: the IF/ID entry becomes a bubble either way.
                        valid_r <= 1'b0;
                        instr_r <= NOP_INSTR;
                        read_r  <= 1'b1;
                        if (imem_busy) begin
                            // Access still in flight: finish it on the old address and discard the word.
                            pending_r <= target_s;
                            state_r   <= FLUSH;
                        end else begin
                            pc_r    <= target_s;
                            state_r <= FETCH;
                        end
                    end else if (!imem_busy) begin
                        if (stall) begin
                            // Decode cannot take the word yet, so park it in the skid entry.
                            skid_r  <= imem_instr;
                            state_r <= HOLD;
                            read_r  <= 1'b0;
                        end else begin
                            pc_out_r   <= pc_r;
                            pc_plus4_r <= pc_inc_s;
                            instr_r    <= imem_instr;
                            valid_r    <= 1'b1;
                            pc_r       <= pc_inc_s;
                            read_r     <= 1'b1;
                        end
                    end else if (!stall) begin
                        // Waiting on memory while decode drains: present a bubble.
                        valid_r <= 1'b0;
                        instr_r <= NOP_INSTR;
                        read_r  <= 1'b1;
                    end else begin
                        // Waiting on memory under a stall: IF/ID keeps its contents.
                        read_r <= 1'b1;
                    end
                end

                HOLD: begin
                    if (branch_taken) begin
                        pc_r    <= target_s;
                        valid_r <= 1'b0;
                        instr_r <= NOP_INSTR;
                        state_r <= FETCH;
                        read_r  <= 1'b1;
                    end else if (!stall) begin
                        pc_out_r   <= pc_r;
                        pc_plus4_r <= pc_inc_s;
                        instr_r    <= skid_r;
                        valid_r    <= 1'b1;
                        pc_r       <= pc_inc_s;
                        state_r    <= FETCH;
                        read_r     <= 1'b1;
                    end else begin
                        read_r <= 1'b0;
                    end
                end

                FLUSH: begin
                    valid_r <= 1'b0;
                    instr_r <= NOP_INSTR;
                    read_r  <= 1'b1;
                    if (branch_taken) begin
                        pending_r <= target_s;
                    end else begin
                        pending_r <= pending_r;
                    end
                    if (!imem_busy) begin
                        // The stale word is dropped here. A redirect that arrives in the same cycle takes priority.
                        pc_r    <= branch_taken ? target_s : pending_r;
                        state_r <= FETCH;
                    end else begin
                        state_r <= FLUSH;
                    end
                end

                default: begin
                    state_r <= FETCH;
                    valid_r <= 1'b0;
                    instr_r <= NOP_INSTR;
                    read_r  <= 1'b1;
                end
            endcase
        end
    end

endmodule
